// File: rtl/lc3_mem_pkg.sv
// Shared types and widths for the LC-3 memory access path.
package lc3_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_state_t;

  localparam int WORD_W = 16;
  localparam int ADDR_W = 16;

  // Counter width able to hold every value 0..n.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mem_access_seq_wait_counter.sv
// Loadable down-counter that times the SRAM wait states; stops at zero.
module wait_counter #(
  parameter int W = 2
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  // No wrap: once at zero it stays there until the next load.
  always_ff @(posedge Clk) begin
    if (Reset)                 cnt <= '0;
    else if (load)             cnt <= load_val;
    else if (dec && cnt != '0) cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mem_access_seq.sv
// SRAM access sequencer: one request per memory cycle, fixed wait states, MDR load on reads.
module mem_access_seq
  import lc3_mem_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] mdr_d,
  output logic              mdr_ld,
  output logic              done
);

  localparam int              CNT_W  = cnt_width(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(WAIT_CYCLES - 1);

  mem_state_t        state;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] mdr_q;
  logic              accept;
  logic              cnt_zero;

  assign accept = (state == IDLE) && req_valid;

  wait_counter #(.W(CNT_W)) u_wait (
    .Clk      (Clk),
    .Reset    (Reset),
    .load     (accept),
    .load_val (RELOAD),
    .dec      (state == ACCESS),
    .zero     (cnt_zero)
  );

  // Requests are latched on acceptance so the control FSM may move on immediately.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mdr_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt_zero) begin
            if (!we_q) mdr_q <= mem_rdata;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready = (state == IDLE);
  assign mem_ce    = (state == ACCESS);
  assign mem_we    = (state == ACCESS) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mdr_d     = mdr_q;
  assign done      = (state == DONE);
  assign mdr_ld    = (state == DONE) && !we_q;

endmodule

// File: tb/tb_mem_access_seq.sv
// Bench for mem_access_seq: directed vector table, corner sequences, random run vs phase model.
module tb_mem_access_seq;

  localparam int W = 2;

  logic        Clk;
  logic        Reset, req_valid, req_we;
  logic [15:0] req_addr, req_wdata, mem_rdata;
  logic        req_ready, mem_ce, mem_we, mdr_ld, done;
  logic [15:0] mem_addr, mem_wdata, mdr_d;

  logic        b_rst, b_valid, b_we;
  logic [15:0] b_addr, b_wdata, b_rdata;
  logic        b_ready, b_ce, b_mwe, b_ld, b_done;
  logic [15:0] b_maddr, b_mwdata, b_mdr;

  int vectors = 0;
  int miscompares = 0;

  mem_access_seq #(.WAIT_CYCLES(W), .ADDR_W(16), .DATA_W(16)) dut (
    .Clk(Clk), .Reset(Reset), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mdr_d(mdr_d), .mdr_ld(mdr_ld), .done(done)
  );

  mem_access_seq #(.WAIT_CYCLES(1), .ADDR_W(16), .DATA_W(16)) dut1 (
    .Clk(Clk), .Reset(b_rst), .req_valid(b_valid), .req_we(b_we),
    .req_addr(b_addr), .req_wdata(b_wdata), .req_ready(b_ready),
    .mem_ce(b_ce), .mem_we(b_mwe), .mem_addr(b_maddr), .mem_wdata(b_mwdata),
    .mem_rdata(b_rdata), .mdr_d(b_mdr), .mdr_ld(b_ld), .done(b_done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct packed {
    logic rst, valid, we;
    logic [15:0] addr, wdata, rdata;
    logic ready, ce, mwe, done, ld;
    logic [15:0] eaddr, ewdata, emdr;
  } vec_t;

  function automatic vec_t mk(input logic rst, valid, we, input logic [15:0] addr, wdata, rdata,
                              input logic ready, ce, mwe, dn, ld,
                              input logic [15:0] eaddr, ewdata, emdr);
    vec_t v;
    v = '{rst, valid, we, addr, wdata, rdata, ready, ce, mwe, dn, ld, eaddr, ewdata, emdr};
    return v;
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  vec_t tbl[17];
  int   mph, dones;
  logic mwe_m;
  logic [15:0] maddr_m, mwd_m, mmdr_m;
  logic e_ce;

  initial begin
    Reset = 1'b1; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; mem_rdata = 0;
    b_rst = 1'b1; b_valid = 0; b_we = 0; b_addr = 0; b_wdata = 0; b_rdata = 0;

    //            rst v we addr      wdata     rdata      rdy ce we dn ld eaddr     ewdata    emdr
    tbl[0]  = mk(1, 0, 0, 16'h0000, 16'h0000, 16'h0000,  1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
    tbl[1]  = mk(0, 1, 0, 16'h3000, 16'h0000, 16'h0000,  0, 1, 0, 0, 0, 16'h3000, 16'h0000, 16'h0000);
    tbl[2]  = mk(0, 0, 0, 16'h0000, 16'h0000, 16'h0000,  0, 1, 0, 0, 0, 16'h3000, 16'h0000, 16'h0000);
    tbl[3]  = mk(0, 0, 0, 16'h0000, 16'h0000, 16'hBEEF,  0, 0, 0, 1, 1, 16'h3000, 16'h0000, 16'hBEEF);
    tbl[4]  = mk(0, 0, 0, 16'h0000, 16'h0000, 16'h0000,  1, 0, 0, 0, 0, 16'h3000, 16'h0000, 16'hBEEF);
    tbl[5]  = mk(0, 1, 1, 16'h3001, 16'h1234, 16'h0000,  0, 1, 1, 0, 0, 16'h3001, 16'h1234, 16'hBEEF);
    tbl[6]  = mk(0, 0, 0, 16'hFFFF, 16'h0000, 16'h0000,  0, 1, 1, 0, 0, 16'h3001, 16'h1234, 16'hBEEF);
    tbl[7]  = mk(0, 0, 0, 16'h0000, 16'h0000, 16'h5555,  0, 0, 0, 1, 0, 16'h3001, 16'h1234, 16'hBEEF);
    tbl[8]  = mk(0, 0, 0, 16'h0000, 16'h0000, 16'h0000,  1, 0, 0, 0, 0, 16'h3001, 16'h1234, 16'hBEEF);
    tbl[9]  = mk(0, 1, 0, 16'h3002, 16'h0000, 16'h0000,  0, 1, 0, 0, 0, 16'h3002, 16'h0000, 16'hBEEF);
    tbl[10] = mk(0, 0, 0, 16'h0000, 16'h0000, 16'h0000,  0, 1, 0, 0, 0, 16'h3002, 16'h0000, 16'hBEEF);
    tbl[11] = mk(0, 0, 0, 16'h0000, 16'h0000, 16'hBEEF,  0, 0, 0, 1, 1, 16'h3002, 16'h0000, 16'hBEEF);
    tbl[12] = mk(0, 0, 0, 16'h0000, 16'h0000, 16'h0000,  1, 0, 0, 0, 0, 16'h3002, 16'h0000, 16'hBEEF);
    tbl[13] = mk(0, 1, 0, 16'h3003, 16'h0000, 16'h0000,  0, 1, 0, 0, 0, 16'h3003, 16'h0000, 16'hBEEF);
    tbl[14] = mk(1, 1, 0, 16'h3005, 16'h0000, 16'h0000,  1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
    tbl[15] = mk(0, 0, 0, 16'h0000, 16'h0000, 16'h0000,  1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
    tbl[16] = mk(0, 0, 0, 16'h0000, 16'h0000, 16'h0000,  1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);

    // directed table: basic read, write, sample timing, reset abort
    for (int i = 0; i < 17; i++) begin
      Reset = tbl[i].rst; req_valid = tbl[i].valid; req_we = tbl[i].we;
      req_addr = tbl[i].addr; req_wdata = tbl[i].wdata; mem_rdata = tbl[i].rdata;
      step();
      chk1 ("tbl.req_ready", req_ready, tbl[i].ready);
      chk1 ("tbl.mem_ce",    mem_ce,    tbl[i].ce);
      chk1 ("tbl.mem_we",    mem_we,    tbl[i].mwe);
      chk1 ("tbl.done",      done,      tbl[i].done);
      chk1 ("tbl.mdr_ld",    mdr_ld,    tbl[i].ld);
      chk16("tbl.mem_addr",  mem_addr,  tbl[i].eaddr);
      chk16("tbl.mem_wdata", mem_wdata, tbl[i].ewdata);
      chk16("tbl.mdr_d",     mdr_d,     tbl[i].emdr);
    end

    // request held through a busy access, address changed after acceptance
    req_valid = 1; req_we = 0; req_addr = 16'h5000; mem_rdata = 16'h0000;
    dones = 0;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (done) dones++;
      if (c == 1) req_addr = 16'h4000;
      if (c == 2) begin chk1("hold.ce2", mem_ce, 1'b1); chk16("hold.addr2", mem_addr, 16'h5000); end
      if (c == 4) begin chk1("hold.ready4", req_ready, 1'b1); chk1("hold.ce4", mem_ce, 1'b0); end
      if (c == 5) begin
        chk1("hold.ce5", mem_ce, 1'b1);
        chk16("hold.addr5", mem_addr, 16'h4000);
        req_valid = 0;
      end
    end
    vectors++;
    if (dones != 2) begin
      miscompares++;
      $display("FAIL hold.done_count: got %0d expected 2", dones);
    end

    // single wait-state build
    b_rst = 0; b_valid = 1; b_we = 0; b_addr = 16'h3000; b_wdata = 16'h7777;
    step();
    chk1("w1.ce1", b_ce, 1'b1);
    chk1("w1.we1", b_mwe, 1'b0);
    chk1("w1.ready1", b_ready, 1'b0);
    chk16("w1.addr1", b_maddr, 16'h3000);
    chk16("w1.wdata1", b_mwdata, 16'h7777);
    b_valid = 0; b_rdata = 16'hABCD;
    step();
    chk1("w1.ce2", b_ce, 1'b0);
    chk1("w1.done2", b_done, 1'b1);
    chk1("w1.ld2", b_ld, 1'b1);
    chk16("w1.mdr2", b_mdr, 16'hABCD);
    b_rdata = 16'h0000;
    step();
    chk1("w1.ready3", b_ready, 1'b1);
    chk1("w1.done3", b_done, 1'b0);
    chk16("w1.mdr3", b_mdr, 16'hABCD);

    // random traffic against a phase-count model (phase 0 idle, 1..W access, W+1 done)
    mph = 0; mwe_m = 0; maddr_m = 0; mwd_m = 0; mmdr_m = 0;
    for (int n = 0; n < 3000; n++) begin
      Reset     = (n == 0) || ($urandom_range(0, 59) == 0);
      req_valid = ($urandom_range(0, 1) == 1);
      req_we    = ($urandom_range(0, 2) == 0);
      req_addr  = 16'($urandom);
      req_wdata = 16'($urandom);
      mem_rdata = 16'($urandom);
      if (Reset) begin
        mph = 0; mwe_m = 0; maddr_m = 0; mwd_m = 0; mmdr_m = 0;
      end else if (mph == 0) begin
        if (req_valid) begin
          mwe_m = req_we; maddr_m = req_addr; mwd_m = req_wdata; mph = 1;
        end
      end else if (mph <= W) begin
        if (mph == W && !mwe_m) mmdr_m = mem_rdata;
        mph++;
      end else begin
        mph = 0;
      end
      step();
      e_ce = (mph >= 1) && (mph <= W);
      chk1 ("rnd.req_ready", req_ready, mph == 0);
      chk1 ("rnd.mem_ce",    mem_ce,    e_ce);
      chk1 ("rnd.mem_we",    mem_we,    e_ce && mwe_m);
      chk1 ("rnd.done",      done,      mph == W + 1);
      chk1 ("rnd.mdr_ld",    mdr_ld,    (mph == W + 1) && !mwe_m);
      chk16("rnd.mem_addr",  mem_addr,  maddr_m);
      chk16("rnd.mem_wdata", mem_wdata, mwd_m);
      chk16("rnd.mdr_d",     mdr_d,     mmdr_m);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
